// File: rtl/if_fetch_queue_s.sv
// Instruction fetch stage: issues sequential reads to a 1-cycle synchronous imem
// and buffers responses in a DEPTH-entry queue with valid/ready output and redirect.
module if_fetch_queue_s #(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 10,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_flush,
  input  logic [XLEN-1:0]         branch_target,
  output logic                    imem_en,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [31:0]             imem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_instr,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    misalign
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam int             CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  logic [XLEN-1:0]  fetch_pc_p0;
  logic             pend_vld_p1;
  logic [XLEN-1:0]  pend_pc_p1;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [CNT_W:0]   credit;
  logic             push;
  logic             pop;

  // Credit counts the in-flight read but ignores a same-cycle pop, so a push always has room.
  assign credit    = {1'b0, count} + {{CNT_W{1'b0}}, pend_vld_p1};
  assign imem_en   = reset & ~is_flush & (credit < DEPTH_C);
  assign imem_addr = fetch_pc_p0[ADDR_W+1:2];

  assign push      = pend_vld_p1 & ~is_flush;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~is_flush;
  assign out_pc    = out_valid ? pc_q[rd_ptr]    : '0;
  assign out_instr = out_valid ? instr_q[rd_ptr] : '0;
  assign occupancy = count;

  // p0 -> p1: request issue, response tracking and queue control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_p0 <= RESET_PC;
      pend_vld_p1 <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      misalign    <= 1'b0;
    end else begin
      misalign <= is_flush & (|branch_target[1:0]);
      if (is_flush) begin
        fetch_pc_p0 <= word_align(branch_target);
        pend_vld_p1 <= 1'b0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
      end else begin
        pend_vld_p1 <= imem_en;
        if (imem_en) fetch_pc_p0 <= fetch_pc_p0 + XLEN'(4);
        if (push)    wr_ptr      <= wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr      <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // p1 -> queue: request PC and returned instruction captured without reset
  always_ff @(posedge clk) begin
    if (imem_en) pend_pc_p1 <= fetch_pc_p0;
    if (push) begin
      pc_q[wr_ptr]    <= pend_pc_p1;
      instr_q[wr_ptr] <= imem_rdata;
    end
  end

endmodule
